// File: rtl/masked_and_hpc2_pipe_if.sv
// masked_and_hpc2_pipe_if: handshake bus for the masked AND gadget
// in_a/in_b/in_rnd/in_valid/in_ready: operand side; out_c/out_valid/out_ready: result side
interface masked_and_hpc2_pipe_if #(parameter int d = 2, parameter int W = 1);
  localparam int NRND = d*(d-1)/2*W;
  logic [d*W-1:0] in_a;
  logic [d*W-1:0] in_b;
  logic [NRND-1:0] in_rnd;
  logic in_valid;
  logic in_ready;
  logic [d*W-1:0] out_c;
  logic out_valid;
  logic out_ready;
  modport master (output in_a, in_b, in_rnd, in_valid, out_ready, input in_ready, out_c, out_valid);
  modport slave (input in_a, in_b, in_rnd, in_valid, out_ready, output in_ready, out_c, out_valid);
endinterface

// File: rtl/masked_and_hpc2_pipe.sv
// masked_and_hpc2_pipe: d-share HPC2 masked AND, W lanes, 2-stage pipeline with valid/ready
// clk/rst: clock, async active-high reset; bus (slave): operand shares in, product shares out
(* keep_hierarchy = "yes" *)
module masked_and_hpc2_and #(parameter int W = 1) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

(* keep_hierarchy = "yes" *)
module masked_and_hpc2_andn #(parameter int W = 1) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~a & b;
endmodule

module masked_and_hpc2_pipe #(
  parameter int d = 2,
  parameter int W = 1,
  parameter int NRND = d*(d-1)/2*W
) (
  input logic clk,
  input logic rst,
  masked_and_hpc2_pipe_if.slave bus
);
  localparam int DW = d*W;
  localparam int PW = d*d*W;
  // pair (i,j) terms live at slot i*d+j; diagonal slots carry constant zero
  function automatic int pidx(input int i, input int j);
    int lo;
    int hi;
    lo = i < j ? i : j;
    hi = i < j ? j : i;
    return lo*d - lo*(lo+1)/2 + hi - lo - 1;
  endfunction
  logic en;
  logic [DW-1:0] a1_q, a1_d, b1_q, b1_d, p_q, p_d, p_n, c;
  logic [NRND-1:0] r1_q, r1_d;
  logic [PW-1:0] v1_q, v1_d, rr, u_q, u_d, u_n, w_q, w_d, w_n;
  logic vld1_q, vld1_d, vld2_q, vld2_d;
  always_comb begin
    en = !vld2_q || bus.out_ready;
    a1_d = en ? bus.in_a : a1_q;
    b1_d = en ? bus.in_b : b1_q;
    r1_d = en ? bus.in_rnd : r1_q;
    vld1_d = en ? bus.in_valid : vld1_q;
    vld2_d = en ? vld1_q : vld2_q;
    p_d = en ? p_n : p_q;
    u_d = en ? u_n : u_q;
    w_d = en ? w_n : w_q;
    v1_d = v1_q;
    rr = '0;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        if (i != j) begin
          if (en) v1_d[(i*d+j)*W +: W] = bus.in_b[j*W +: W] ^ bus.in_rnd[pidx(i, j)*W +: W];
          rr[(i*d+j)*W +: W] = r1_q[pidx(i, j)*W +: W];
        end
    c = p_q;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        c[i*W +: W] = c[i*W +: W] ^ u_q[(i*d+j)*W +: W] ^ w_q[(i*d+j)*W +: W];
  end
  for (genvar i = 0; i < d; i++) begin : g_s
    masked_and_hpc2_and #(.W(W)) u_p (.a(a1_q[i*W +: W]), .b(b1_q[i*W +: W]), .y(p_n[i*W +: W]));
    for (genvar j = 0; j < d; j++) begin : g_p
      masked_and_hpc2_andn #(.W(W)) u_u (.a(a1_q[i*W +: W]), .b(rr[(i*d+j)*W +: W]), .y(u_n[(i*d+j)*W +: W]));
      masked_and_hpc2_and #(.W(W)) u_w (.a(a1_q[i*W +: W]), .b(v1_q[(i*d+j)*W +: W]), .y(w_n[(i*d+j)*W +: W]));
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a1_q <= '0;
      b1_q <= '0;
      r1_q <= '0;
      v1_q <= '0;
      vld1_q <= 1'b0;
      p_q <= '0;
      u_q <= '0;
      w_q <= '0;
      vld2_q <= 1'b0;
    end else begin
      a1_q <= a1_d;
      b1_q <= b1_d;
      r1_q <= r1_d;
      v1_q <= v1_d;
      vld1_q <= vld1_d;
      p_q <= p_d;
      u_q <= u_d;
      w_q <= w_d;
      vld2_q <= vld2_d;
    end
  assign bus.in_ready = en;
  assign bus.out_valid = vld2_q;
  assign bus.out_c = c;
endmodule

// File: tb/tb_masked_and_hpc2_pipe.sv
// tb_masked_and_hpc2_pipe: randomized self-checking bench for the masked AND gadget
module tb_masked_and_hpc2_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  masked_and_hpc2_pipe_if #(.d(2), .W(1)) i2 ();
  masked_and_hpc2_pipe_if #(.d(3), .W(8)) i3 ();
  masked_and_hpc2_pipe #(.d(2), .W(1)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));
  masked_and_hpc2_pipe #(.d(3), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(i3.slave));
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  function automatic logic [7:0] unmask3(input logic [23:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16];
  endfunction
  task automatic rand3(input logic v);
    i3.in_a = 24'($urandom);
    i3.in_b = 24'($urandom);
    i3.in_rnd = 24'($urandom);
    i3.in_valid = v;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    i2.in_valid = 1'b0; i2.out_ready = 1'b0; i2.in_a = '0; i2.in_b = '0; i2.in_rnd = '0;
    rand3(1'b0); i3.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (i2.out_valid !== 1'b0 || i2.out_c !== 2'b00) begin failures++; $display("FAIL reset_d2 got ov=%b c=%b exp ov=0 c=00", i2.out_valid, i2.out_c); end
    checks++; if (i3.out_valid !== 1'b0 || i3.out_c !== 24'h0) begin failures++; $display("FAIL reset_d3 got ov=%b c=%h exp ov=0 c=0", i3.out_valid, i3.out_c); end
    rst = 1'b0;
    #1;
    checks++; if (i2.in_ready !== 1'b1 || i3.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b/%b exp 1/1", i2.in_ready, i3.in_ready); end
    i2.out_ready = 1'b1; i3.out_ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_d2();
    i2.in_a = 2'b01; i2.in_b = 2'b10; i2.in_rnd = 1'b1; i2.in_valid = 1'b1; i2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      checks++; if (i2.out_valid !== (cyc == 2)) begin failures++; $display("FAIL single_ov cyc=%0d got=%b exp=%b", cyc, i2.out_valid, cyc == 2); end
      if (cyc == 2) begin
        checks++; if (i2.out_c !== 2'b10) begin failures++; $display("FAIL single_c got=%b exp=10", i2.out_c); end
      end
      next_cycle();
      i2.in_valid = 1'b0;
    end
  endtask

  task automatic test_stream();
    logic [7:0] e;
    int got = 0;
    exp_q.delete();
    i3.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1002; cyc++) begin
      rand3(cyc < 1000);
      #1;
      checks++; if (i3.out_valid !== (cyc >= 2) || i3.in_ready !== 1'b1) begin failures++; $display("FAIL stream_hs cyc=%0d got ov=%b rdy=%b exp ov=%b rdy=1", cyc, i3.out_valid, i3.in_ready, cyc >= 2); end
      if (i3.out_valid && i3.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra cyc=%0d got result exp none", cyc); end
        else begin
          e = exp_q.pop_front();
          if (unmask3(i3.out_c) !== e) begin failures++; $display("FAIL stream_val cyc=%0d got=%h exp=%h", cyc, unmask3(i3.out_c), e); end
        end
      end
      if (i3.in_valid && i3.in_ready) exp_q.push_back(unmask3(i3.in_a) & unmask3(i3.in_b));
      next_cycle();
    end
    checks++; if (got !== 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", got); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] e;
    logic [23:0] held = '0;
    logic prev_stall = 1'b0;
    logic renew = 1'b0;
    int sent = 0, got = 0, stall = 0;
    exp_q.delete();
    rand3(1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (renew) rand3(sent < 4);
      renew = 1'b0;
      i3.out_ready = !(i3.out_valid && stall < 5);
      #1;
      if (prev_stall) begin
        checks++; if (i3.out_c !== held || i3.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got ov=%b c=%h exp ov=1 c=%h", cyc, i3.out_valid, i3.out_c, held); end
      end
      if (!i3.out_ready) begin
        checks++; if (i3.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, i3.in_ready); end
        held = i3.out_c;
        stall++;
      end
      prev_stall = !i3.out_ready;
      if (i3.out_valid && i3.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra cyc=%0d got result exp none", cyc); end
        else begin
          e = exp_q.pop_front();
          if (unmask3(i3.out_c) !== e) begin failures++; $display("FAIL bp_val cyc=%0d got=%h exp=%h", cyc, unmask3(i3.out_c), e); end
        end
      end
      if (i3.in_valid && i3.in_ready) begin
        exp_q.push_back(unmask3(i3.in_a) & unmask3(i3.in_b));
        sent++;
        renew = 1'b1;
      end
      next_cycle();
    end
    checks++; if (got !== 4 || exp_q.size() != 0 || stall !== 5) begin failures++; $display("FAIL bp_count got=%0d left=%0d stalls=%0d exp 4/0/5", got, exp_q.size(), stall); end
    i3.in_valid = 1'b0; i3.out_ready = 1'b1;
  endtask

  task automatic test_randomness();
    logic [1:0] seen0 = 2'b00, seen1 = 2'b00;
    int got = 0;
    i2.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i2.in_a = {~k[0], k[0]};
      i2.in_b = {~k[1], k[1]};
      i2.in_rnd = k[2];
      i2.in_valid = k < 8;
      #1;
      if (i2.out_valid) begin
        got++;
        checks++; if ((i2.out_c[0] ^ i2.out_c[1]) !== 1'b1) begin failures++; $display("FAIL rnd_xor k=%0d got=%b exp=1", k, i2.out_c[0] ^ i2.out_c[1]); end
        seen0[i2.out_c[0]] = 1'b1;
        seen1[i2.out_c[1]] = 1'b1;
      end
      next_cycle();
    end
    checks++; if (seen0 !== 2'b11 || seen1 !== 2'b11 || got !== 8) begin failures++; $display("FAIL rnd_spread got seen0=%b seen1=%b n=%0d exp 11/11/8", seen0, seen1, got); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    i3.out_ready = 1'b1;
    rand3(1'b1);
    next_cycle();
    rand3(1'b1);
    next_cycle();
    i3.in_valid = 1'b0;
    #1;
    checks++; if (i3.out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got ov=%b exp=1", i3.out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (i3.out_valid !== 1'b0 || i3.out_c !== 24'h0) begin failures++; $display("FAIL rmid_async got ov=%b c=%h exp ov=0 c=0", i3.out_valid, i3.out_c); end
    next_cycle();
    rst = 1'b0;
    i3.out_ready = 1'b0;
    #1;
    checks++; if (i3.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", i3.in_ready); end
    i3.out_ready = 1'b1;
    rand3(1'b1);
    e = unmask3(i3.in_a) & unmask3(i3.in_b);
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      checks++; if (i3.out_valid !== (cyc == 2)) begin failures++; $display("FAIL rmid_ov cyc=%0d got=%b exp=%b", cyc, i3.out_valid, cyc == 2); end
      if (cyc == 2) begin
        checks++; if (unmask3(i3.out_c) !== e) begin failures++; $display("FAIL rmid_val got=%h exp=%h", unmask3(i3.out_c), e); end
      end
      next_cycle();
      i3.in_valid = 1'b0;
    end
  endtask

  task automatic test_bubble();
    logic [7:0] e;
    int acc = 0, got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      rand3(cyc < 40 && cyc % 2 == 0);
      i3.out_ready = cyc >= 40 || cyc % 4 < 2;
      #1;
      if (i3.out_valid && i3.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bub_extra cyc=%0d got result exp none", cyc); end
        else begin
          e = exp_q.pop_front();
          if (unmask3(i3.out_c) !== e) begin failures++; $display("FAIL bub_val cyc=%0d got=%h exp=%h", cyc, unmask3(i3.out_c), e); end
        end
      end
      if (i3.in_valid && i3.in_ready) begin
        exp_q.push_back(unmask3(i3.in_a) & unmask3(i3.in_b));
        acc++;
      end
      next_cycle();
    end
    checks++; if (got !== acc || acc == 0 || exp_q.size() != 0) begin failures++; $display("FAIL bub_count got=%0d exp=%0d left=%0d", got, acc, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_d2();
    test_stream();
    test_back_pressure();
    test_randomness();
    test_reset_mid();
    test_bubble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/masked_and_hpc2_pipe.md
Name: masked_and_hpc2_pipe

Overview:
- Parametrised d-share HPC2 masked AND gadget: W parallel bit-lanes, internal 2-stage register pipeline, valid/ready handshake on both sides.
- Successor to the trivial unmasked gate cell.
- Drop-in nonlinear primitive for the S-box datapath and other masked logic that needs back-pressure.
- Consumes fresh randomness only on accepted transfers.

Parameters:
- d, 2, number of shares (d >= 2).
- W, 1, bit-lanes per share.
- NRND, d*(d-1)/2*W, randomness bus width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_a  input  d*W  operand a shares; share s at bits [s*W +: W].
- in_b  input  d*W  operand b shares, same layout.
- in_rnd  input  NRND  fresh randomness r_ij for pairs i<j in lexicographic order (0,1),(0,2)..(d-2,d-1); pair k at bits [k*W +: W].
- in_valid  input  1  a, b and rnd valid.
- in_ready  output  1  gadget accepts this cycle.
- out_c  output  d*W  product shares, same layout.
- out_valid  output  1  out_c valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async, immediate on rst high):
  - All pipeline registers (data and valid) clear to 0.
  - out_valid=0; out_c=0.
  - in_ready=1 once reset is released; while rst is high, in_ready is don't-care and no transfer occurs.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational, with no dependency on in_valid.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - When en=0, every register holds, both data and valid. This is mandatory: masked data must not be re-randomised or corrupted while stalled.
- Stage 1, loads when en=1:
  - a1_i=a_i, b1_i=b_i.
  - r1_ij=r_ij.
  - v1_ij = b_j XOR r_ij for all i != j, with r_ji = r_ij.
  - vld1 = in_valid.
  - Data registers load even when in_valid=0; only vld1 qualifies them.
- Stage 2, loads when en=1:
  - p_i = a1_i AND b1_i.
  - u_ij = (NOT a1_i) AND r1_ij.
  - w_ij = a1_i AND v1_ij.
  - vld2 = vld1.
- Output:
  - out_c_i = p_i XOR (XOR over j != i of (u_ij XOR w_ij)), combinational from stage-2 registers only.
  - out_valid = vld2.
- Latency: exactly 2 enabled cycles. Throughput 1 op/cycle with out_ready held high.
- Correctness: XOR of all out_c shares equals (XOR of in_a shares) AND (XOR of in_b shares), per lane.
- Security rules:
  - Every AND/NOT-AND term is instantiated as a separate keep-hierarchy gate cell.
  - No logic merges shares i and j before a stage-2 register, except through v1_ij and r1_ij.
  - Synthesis must not flatten the gadget.
- Boundary cases:
  - Stall with a full pipeline: both entries are retained; no loss, no duplication.
  - Simultaneous output transfer and input transfer: pipeline advances, and the new operand enters stage 1 in the same cycle.
  - out_ready=0 with out_valid=0: pipeline still advances; bubbles are collapsed.
  - Reset mid-operation: in-flight results are discarded; the first accepted input after reset emerges 2 cycles later.
  - in_rnd is sampled only on enabled edges; the provider must hold it stable with in_a/in_b.

Test Plan:
- d=2, W=1; in_a=2'b01 (a=1), in_b=2'b10 (b=1), in_rnd=1; valid for one cycle, out_ready=1 -> out_valid high exactly 2 cycles later, out_c=2'b10 (XOR=1), then out_valid=0.
- d=3, W=8; 1000 random a, b, rnd streamed back-to-back with out_ready=1 -> one result per cycle after 2-cycle latency; unmasked out_c equals a&b for every vector, in order.
- Back-pressure: stream 4 ops, hold out_ready=0 for 5 cycles after the first result -> in_ready=0 during the stall, out_c stable and unchanged each cycle, all 4 results delivered in order with no duplicates.
- Randomness independence, d=2, W=1: fix a=1, b=1 and sweep share splits and rnd -> unmasked result is always 1; each single out_c share takes both values 0 and 1 across rnd values.
- Reset mid-flight: accept 2 ops, assert rst asynchronously between edges -> out_valid and out_c drop to 0 immediately; after release, in_ready=1, and a new op emerges after exactly 2 cycles.
- Bubble collapse: input every other cycle with out_ready toggling -> no lost or duplicated results; out_valid count equals the accepted count.
